// File: rtl/counter_share_arbiter.sv
// Round-robin owner selection for one shared WIDTH-bit up-counter.
// The granted requester gets an interval of term+1 counting cycles, ended by a done pulse or by an abort.
`timescale 1ns/1ps
module counter_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16
) (
  input  logic                     Clock,
  input  logic                     Reset_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   len,
  output logic [N_REQ-1:0]         grant,
  output logic                     busy,
  output logic [WIDTH-1:0]         cnt,
  output logic [N_REQ-1:0]         done,
  output logic                     rollover
);

  localparam int PW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PW1 = PW + 1;

  typedef enum logic {S_IDLE, S_COUNT} state_t;

  state_t           r_state;
  logic [N_REQ-1:0] r_grant;
  logic [N_REQ-1:0] r_done;
  logic             r_rollover;
  logic             r_busy;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_term;
  logic [PW-1:0]    r_ptr;

  logic             w_found;
  logic [PW-1:0]    w_sel;
  logic [N_REQ-1:0] w_sel_oh;
  logic [WIDTH-1:0] w_sel_len;
  logic [PW1-1:0]   w_idx;

  // Search starts one past the last owner, so the last owner has the lowest priority.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_found   = 1'b0;
    w_sel     = '0;
    w_sel_oh  = '0;
    w_sel_len = '0;
    w_idx     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = {1'b0, r_ptr} + PW1'(k);
      if (w_idx >= PW1'(N_REQ))
        w_idx = w_idx - PW1'(N_REQ);
      if (!w_found && req[w_idx[PW-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_idx[PW-1:0];
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (w_sel == PW'(i)) begin
        w_sel_oh[i] = 1'b1;
        w_sel_len   = len[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_done     <= '0;
      r_rollover <= 1'b0;
      r_busy     <= 1'b0;
      r_cnt      <= '0;
      r_term     <= '0;
      r_ptr      <= PW'(N_REQ - 1);
    end else begin
      // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
      r_done     <= '0;
      r_rollover <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_found) begin
            r_grant <= w_sel_oh;
            r_term  <= w_sel_len;
            r_ptr   <= w_sel;
            r_busy  <= 1'b1;
            r_state <= S_COUNT;
          end
        end
        S_COUNT: begin
          // An abort wins over a completion falling on the same edge.
          if ((req & r_grant) == '0) begin
            r_grant <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_cnt == r_term) begin
            r_done     <= r_grant;
            r_rollover <= 1'b1;
            r_grant    <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + WIDTH'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant    = r_grant;
  assign busy     = r_busy;
  assign cnt      = r_cnt;
  assign done     = r_done;
  assign rollover = r_rollover;

endmodule

// File: tb/tb_counter_share_arbiter.sv
// Directed bench for counter_share_arbiter: grant order, interval timing, abort, len sampling, full-range count, async reset.
`timescale 1ns/1ps
module tb_counter_share_arbiter;

  localparam int N_REQ = 4;
  localparam int WIDTH = 16;

  logic                   Clock = 1'b0;
  logic                   Reset_n;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] len;
  logic [N_REQ-1:0]       grant;
  logic                   busy;
  logic [WIDTH-1:0]       cnt;
  logic [N_REQ-1:0]       done;
  logic                   rollover;

  int n_cmp = 0;
  int n_mis = 0;

  counter_share_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .req(req), .len(len),
    .grant(grant), .busy(busy), .cnt(cnt), .done(done), .rollover(rollover)
  );

  always #5 Clock = ~Clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample 1 ns after the rising edge; inputs changed here act on the next edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_len(input int idx, input logic [WIDTH-1:0] v);
    len[idx*WIDTH +: WIDTH] = v;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_grant"}, 32'(grant), 32'h0);
    check({tag, "_busy"},  32'(busy),  32'h0);
    check({tag, "_cnt"},   32'(cnt),   32'h0);
  endtask

  logic [N_REQ-1:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  int bad_steps;

  initial begin
    Reset_n = 1'b0;
    req     = '0;
    len     = '0;
    #12;
    check_idle("reset");
    check("reset_done", 32'(done), 32'h0);
    check("reset_roll", 32'(rollover), 32'h0);
    @(negedge Clock);
    Reset_n = 1'b1;

    // Single request, term 3
    req = 4'b0001;
    set_len(0, 16'd3);
    tick();
    check("t1_grant", 32'(grant), 32'h1);
    check("t1_busy", 32'(busy), 32'h1);
    check("t1_cnt0", 32'(cnt), 32'h0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("t1_cnt", 32'(cnt), 32'(k));
      check("t1_nodone", 32'(done), 32'h0);
    end
    tick();
    check("t1_done", 32'(done), 32'h1);
    check("t1_roll", 32'(rollover), 32'h1);
    check_idle("t1_end");
    req = '0;
    tick();
    check("t1_done_clr", 32'(done), 32'h0);
    check("t1_roll_clr", 32'(rollover), 32'h0);

    // Reset so the pointer starts over, then all requesters held with term 0
    #2 Reset_n = 1'b0;
    #3 Reset_n = 1'b1;
    len = '0;
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      check("t2_grant", 32'(grant), 32'(exp_g[g]));
      check("t2_busy", 32'(busy), 32'h1);
      tick();
      check("t2_done", 32'(done), 32'(exp_g[g]));
      check("t2_roll", 32'(rollover), 32'h1);
      check("t2_grant_gap", 32'(grant), 32'h0);
    end

    // Abort: req[1] drops at cnt 5
    req = 4'b0010;
    set_len(1, 16'd10);
    tick();
    check("t3_grant", 32'(grant), 32'h2);
    for (int k = 1; k <= 5; k++) tick();
    check("t3_cnt5", 32'(cnt), 32'h5);
    req = '0;
    tick();
    check_idle("t3_abort");
    check("t3_nodone", 32'(done), 32'h0);
    check("t3_noroll", 32'(rollover), 32'h0);
    tick();
    check("t3_nodone_late", 32'(done), 32'h0);

    // Abort coinciding with completion (term 0): no pulse
    req = 4'b1000;
    set_len(3, 16'd0);
    tick();
    check("tp_grant", 32'(grant), 32'h8);
    req = '0;
    tick();
    check_idle("tp_abort");
    check("tp_nodone", 32'(done), 32'h0);
    check("tp_noroll", 32'(rollover), 32'h0);

    // len change during COUNT is ignored
    req = 4'b0001;
    set_len(0, 16'd8);
    tick();
    check("t5_grant", 32'(grant), 32'h1);
    tick();
    check("t5_cnt1", 32'(cnt), 32'h1);
    set_len(0, 16'd2);
    for (int k = 2; k <= 8; k++) begin
      tick();
      check("t5_cnt", 32'(cnt), 32'(k));
      check("t5_nodone", 32'(done), 32'h0);
    end
    tick();
    check("t5_done", 32'(done), 32'h1);
    check("t5_cnt_end", 32'(cnt), 32'h0);
    req = '0;
    tick();

    // Full-range interval: 65536 COUNT cycles, no wrap before done
    req = 4'b0100;
    set_len(2, 16'hFFFF);
    tick();
    check("t4_grant", 32'(grant), 32'h4);
    check("t4_cnt0", 32'(cnt), 32'h0);
    bad_steps = 0;
    for (int k = 1; k <= 65535; k++) begin
      tick();
      if (cnt !== WIDTH'(k) || done !== '0 || busy !== 1'b1) bad_steps++;
    end
    check("t4_bad_steps", 32'(bad_steps), 32'h0);
    check("t4_cnt_max", 32'(cnt), 32'hFFFF);
    tick();
    check("t4_done", 32'(done), 32'h4);
    check("t4_roll", 32'(rollover), 32'h1);
    check_idle("t4_end");
    req = '0;
    tick();
    check("t4_single_done", 32'(done), 32'h0);

    // Asynchronous reset mid-interval
    req = 4'b0100;
    set_len(2, 16'd10);
    tick();
    check("t6_grant", 32'(grant), 32'h4);
    for (int k = 1; k <= 4; k++) tick();
    check("t6_cnt4", 32'(cnt), 32'h4);
    #2 Reset_n = 1'b0;
    #1;
    check_idle("t6_reset");
    check("t6_done", 32'(done), 32'h0);
    req = 4'b0101;
    #2 Reset_n = 1'b1;
    tick();
    check("t6_first_grant", 32'(grant), 32'h1);
    check("t6_cnt_restart", 32'(cnt), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
